first_nios2_system_sysid_master: RTL and testbench
==================================================

# first_nios2_system_sysid_master

Avalon-MM read master that interrogates the system ID peripheral. On a start pulse it reads the ID word (word address 0) and then the build timestamp (word address 1), compares both with build-time expected values, and reports pass/fail, mismatch and timeout status. It sits beside the Nios II on the system interconnect as a hardware self-check, so a boot monitor or LED driver can confirm that the FPGA image matches the software build.

## Interface
- `EXPECTED_ID`, 32'd0, expected value at word address 0.
- `EXPECTED_TIMESTAMP`, 32'd1521152775, expected value at word address 1.
- `TIMEOUT_CYCLES`, 16, maximum consecutive waitrequest cycles per read; 0 disables the timeout.
- `TO_WIDTH`, 16, width of the timeout counter; `TIMEOUT_CYCLES` must be ≤ 2^TO_WIDTH−1.

Ports:
- `clock`  in  1  single system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a check; ignored while `busy`.
- `address`  out  1  Avalon word address sent to the sysid slave.
- `read`  out  1  Avalon read strobe.
- `waitrequest`  in  1  slave stall; a read is accepted on a cycle with `read`=1 and `waitrequest`=0.
- `readdata`  in  32  slave data, valid on the accept cycle (fixed read latency 0).
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle `done` is high.
- `done`  out  1  one-cycle completion pulse.
- `pass`  out  1  both words matched and no timeout; held until the next accepted start.
- `id_mismatch`  out  1  ID word differed from `EXPECTED_ID`.
- `ts_mismatch`  out  1  timestamp word differed from `EXPECTED_TIMESTAMP`.
- `timeout`  out  1  a read exceeded `TIMEOUT_CYCLES`.
- `id_value`  out  32  captured ID word.
- `ts_value`  out  32  captured timestamp word.

## Operation
- State machine states: IDLE, RD_ID, RD_TS, FINISH.
- IDLE: `read`=0. If `start`=1, clear all status flags, `pass`, `id_value` and `ts_value`, then go to RD_ID.
- RD_ID: `read`=1, `address`=0. On accept, capture `readdata` into `id_value`, set `id_mismatch` = (readdata ≠ EXPECTED_ID), clear the timeout counter, and go to RD_TS.
- RD_TS: `read`=1, `address`=1. On accept, capture `ts_value`, set `ts_mismatch`, and go to FINISH.
- FINISH: `done`=1 for one cycle; `pass` = !id_mismatch & !ts_mismatch & !timeout; then return to IDLE.
- Timeout: in RD_ID and RD_TS the counter increments on every cycle with `waitrequest`=1. If the counter reaches `TIMEOUT_CYCLES` (nonzero) while `waitrequest` is still 1, set `timeout`, drop `read` on the next cycle, skip any remaining read, and go to FINISH. Words not read keep the value 0, and their mismatch flag stays 0.
- `address`, `read` and the other Avalon outputs stay stable while `waitrequest`=1; the master never abandons a read except on timeout.
- A `start` pulse in any state other than IDLE is ignored, with no queueing.
- Reset values: all outputs are 0, the state is IDLE, and the counter is 0. Reset asserted mid-read drops `read` immediately, because the reset is asynchronous, and no `done` pulse is produced.

## Timing
- All outputs are registered; no output depends combinationally on an input.
- With a zero-wait-state slave: `start` sampled at edge 0; `read`/addr0 high during cycle 0–1; `read`/addr1 high during cycle 1–2; `done` high during cycle 2–3. Start-to-done latency is therefore 3 cycles.
- Each waitrequest cycle extends the corresponding phase by exactly one cycle.
- `pass`, the flags and the captured values are valid in the same cycle as `done` and hold until the next accepted `start`.
- If `start` coincides with `done`, the `start` is ignored, because the block is not yet in IDLE.
- The timeout boundary, with `TIMEOUT_CYCLES`=N: a read accepted after exactly N−1 stall cycles succeeds; N stall cycles produce a timeout.

## Test plan
- Zero-wait slave returns 0 at address 0 and 1521152775 at address 1 -> `done` pulses 3 cycles after `start`; `pass`=1; `id_value`=0; `ts_value`=1521152775.
- Slave returns 0x00000001 at address 0 -> `id_mismatch`=1, `ts_mismatch`=0, `pass`=0, `id_value`=1.
- Slave holds waitrequest for 5 cycles on each read (`TIMEOUT_CYCLES`=16) -> `done` at cycle 13; `pass`=1; `read`/`address` stable throughout each stall.
- Slave holds waitrequest permanently in the RD_TS phase (`TIMEOUT_CYCLES`=16) -> `timeout`=1, `ts_value`=0, `ts_mismatch`=0, `pass`=0; `done` pulses; `read` drops after 16 stall cycles. A stall of 15 cycles passes.
- Extra `start` pulses while `busy`, plus `start` on the `done` cycle -> only one transaction pair per accepted start; the monitor counts exactly 2 reads.
- Reset asserted during RD_ID with waitrequest=1 -> `read`=0 asynchronously; all outputs are 0; no `done` pulse; a fresh `start` afterwards completes with `pass`=1.

Source files
------------

// File: rtl/first_nios2_system_sysid_master.sv
// Avalon-MM read master that checks the system ID peripheral.
// After a start request it reads the ID word (address 0) and then the
// build timestamp (address 1). Both are compared with build-time constants
// and the result is reported as pass / mismatch / timeout status.
// Reads have zero read latency: data is taken on the accept cycle.
module first_nios2_system_sysid_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1521152775,
  parameter int unsigned TIMEOUT_CYCLES     = 16,
  parameter int unsigned TO_WIDTH           = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // A zero TIMEOUT_CYCLES disables the stall limit. TO_LAST is the count
  // that, together with one more stalled cycle, means the limit is reached.
  localparam bit                  TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t              state;
  state_t              state_next;
  logic [TO_WIDTH-1:0] to_cnt;

  logic in_read;
  logic accept;
  logic to_hit;

  // Handshake decode: a read is in flight in RD_ID and RD_TS only. The
  // timeout fires on the Nth consecutive stalled cycle of the same read.
  assign in_read = (state == RD_ID) || (state == RD_TS);
  assign accept  = in_read && !waitrequest;
  assign to_hit  = TO_EN && in_read && waitrequest && (to_cnt == TO_LAST);

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of the others, independent of order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start is honoured only in IDLE; a timed-out read skips
  // straight to FINISH so an unread timestamp is never requested.
  // NOTE: the default assignment at the top keeps this block free of
  // inferred latches on paths that do not change state.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = RD_ID;
        end
      end
      RD_ID: begin
        if (accept) begin
          state_next = RD_TS;
        end else if (to_hit) begin
          state_next = FINISH;
        end
      end
      RD_TS: begin
        if (accept || to_hit) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bus and handshake outputs decoded from the state register only, so they
  // hold steady through stalls and never follow an input combinationally.
  always_comb begin
    read    = 1'b0;
    address = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
      end
      RD_ID: begin
        read    = 1'b1;
        address = 1'b0;
        busy    = 1'b1;
      end
      RD_TS: begin
        read    = 1'b1;
        address = 1'b1;
        busy    = 1'b1;
      end
      FINISH: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Datapath: stall counter, captured words and status flags. Results are
  // cleared when a check is accepted and otherwise held for software.
  // pass is resolved on the cycle the last read completes so that it is
  // already valid while done is high.
  // NOTE: every flop here is a handful of control/status bits and two data
  // words, all of which are reset so the outputs read 0 straight after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt      <= '0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            to_cnt      <= '0;
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
          end
        end
        RD_ID: begin
          if (accept) begin
            id_value    <= readdata;
            id_mismatch <= (readdata != EXPECTED_ID);
            to_cnt      <= '0;
          end else begin
            to_cnt <= to_cnt + TO_WIDTH'(1);
            if (to_hit) begin
              timeout <= 1'b1;
            end
          end
        end
        RD_TS: begin
          if (accept) begin
            ts_value    <= readdata;
            ts_mismatch <= (readdata != EXPECTED_TIMESTAMP);
            pass        <= !id_mismatch && (readdata == EXPECTED_TIMESTAMP) && !timeout;
            to_cnt      <= '0;
          end else begin
            to_cnt <= to_cnt + TO_WIDTH'(1);
            if (to_hit) begin
              timeout <= 1'b1;
            end
          end
        end
        FINISH: begin
          to_cnt <= '0;
        end
        default: begin
          to_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_first_nios2_system_sysid_master.sv
// Self-checking bench for first_nios2_system_sysid_master.
// A slave model answers reads with planned stall counts and data. A
// transaction-level model predicts every output from the start edge and the
// plan using phase lengths, and is compared with the DUT on every negedge.
module tb_first_nios2_system_sysid_master;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1521152775;
  localparam int          N      = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = 32'd0;
  logic        address, read, busy, done, pass;
  logic        id_mismatch, ts_mismatch, timeout;
  logic [31:0] id_value, ts_value;

  always #5 clock = ~clock;

  first_nios2_system_sysid_master dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .address     (address),
    .read        (read),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .id_mismatch (id_mismatch),
    .ts_mismatch (ts_mismatch),
    .timeout     (timeout),
    .id_value    (id_value),
    .ts_value    (ts_value)
  );

  typedef struct packed {
    logic        read;
    logic        address;
    logic        busy;
    logic        done;
    logic        pass;
    logic        id_mm;
    logic        ts_mm;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;
  } obs_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plan for the next transaction (stalls and data per word address).
  int          plan_stall [2];
  logic [31:0] plan_data  [2];

  // ---------------- transaction-level model ----------------
  bit          have_txn = 1'b0;
  longint      edge_n   = 0;
  longint      e0       = 0;
  int          m_sid    = 0;
  int          m_sts    = 0;
  logic [31:0] m_did    = '0;
  logic [31:0] m_dts    = '0;

  function automatic longint lid_len();
    return (m_sid >= N) ? N : m_sid + 1;
  endfunction

  function automatic longint lts_len();
    if (m_sid >= N) return 0;
    return (m_sts >= N) ? N : m_sts + 1;
  endfunction

  function automatic bit model_idle(input longint n);
    return !have_txn || (n - e0 >= lid_len() + lts_len() + 2);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      have_txn <= 1'b0;
    end else begin
      edge_n <= edge_n + 1;
      if (start && model_idle(edge_n + 1)) begin
        have_txn <= 1'b1;
        e0       <= edge_n + 1;
        m_sid    <= plan_stall[0];
        m_sts    <= plan_stall[1];
        m_did    <= plan_data[0];
        m_dts    <= plan_data[1];
      end
    end
  end

  function automatic obs_t model_out();
    obs_t   o;
    longint c, lid, cd;
    bit     tid, tts;
    o = '0;
    if (!have_txn) return o;
    c   = edge_n - e0;
    lid = lid_len();
    cd  = lid + lts_len();
    tid = (m_sid >= N);
    tts = !tid && (m_sts >= N);
    o.read    = (c < cd);
    o.address = (c >= lid);
    o.busy    = (c <= cd);
    o.done    = (c == cd);
    if (!tid && c >= lid) begin
      o.id_value = m_did;
      o.id_mm    = (m_did != EXP_ID);
    end
    if (!tid && !tts && c >= cd) begin
      o.ts_value = m_dts;
      o.ts_mm    = (m_dts != EXP_TS);
    end
    o.timeout = (tid && c >= lid) || (tts && c >= cd);
    o.pass    = (c >= cd) && !tid && !tts && (m_did == EXP_ID) && (m_dts == EXP_TS);
    return o;
  endfunction

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      obs_t a, e;
      @(negedge clock);
      a = {read, address, busy, done, pass, id_mismatch, ts_mismatch, timeout, id_value, ts_value};
      e = model_out();
      if (!e.read) begin
        a.address = 1'b0;
        e.address = 1'b0;
      end
      check("cycle_outputs", a, e);
    end
  end

  // ---------------- Avalon slave ----------------
  int   accepts      = 0;
  int   addr1_cycles = 0;
  int   pend         = 0;
  logic last_read    = 1'b0;
  logic last_wr      = 1'b0;

  initial begin
    forever begin
      logic wr;
      @(negedge clock);
      if (last_read && !last_wr) begin
        accepts++;
        pend = 0;
      end else if (last_read) begin
        pend++;
      end
      if (!read) pend = 0;
      if (read && address) addr1_cycles++;
      if (read) begin
        wr       = (pend < plan_stall[address]);
        readdata = wr ? $urandom : plan_data[address];
      end else begin
        wr       = 1'($urandom_range(0, 1));
        readdata = $urandom;
      end
      waitrequest = wr;
      last_read   = read;
      last_wr     = wr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_txn(input int sid, input int sts, input logic [31:0] did,
                         input logic [31:0] dts, output int lat);
    plan_stall[0] = sid;
    plan_stall[1] = sts;
    plan_data[0]  = did;
    plan_data[1]  = dts;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 300) begin
      @(negedge clock);
      lat++;
    end
    if (done !== 1'b1) check("done_wait_expired", {71'd0, done}, 72'd1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, a0, c0;
    plan_stall[0] = 0;
    plan_stall[1] = 0;
    plan_data[0]  = EXP_ID;
    plan_data[1]  = EXP_TS;

    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_outputs",
          {read, busy, done, pass, id_mismatch, ts_mismatch, timeout, id_value, ts_value}, '0);

    // Zero-wait, matching words.
    run_txn(0, 0, EXP_ID, EXP_TS, lat);
    check("zw_latency", lat, 2);
    check("zw_pass", pass, 1);
    check("zw_id_value", id_value, 32'd0);
    check("zw_ts_value", ts_value, 32'd1521152775);

    // ID mismatch.
    run_txn(0, 0, 32'h1, EXP_TS, lat);
    check("idmm_flags", {id_mismatch, ts_mismatch, pass}, 3'b100);
    check("idmm_id_value", id_value, 32'h1);

    // Five stall cycles on each read.
    run_txn(5, 5, EXP_ID, EXP_TS, lat);
    check("stall5_latency", lat, 12);
    check("stall5_pass", pass, 1);

    // Permanent stall on the timestamp read.
    c0 = addr1_cycles;
    run_txn(0, 1000, EXP_ID, EXP_TS, lat);
    check("to_ts_latency", lat, 17);
    check("to_ts_flags", {timeout, ts_mismatch, pass}, 3'b100);
    check("to_ts_value", ts_value, 32'd0);
    repeat (2) @(negedge clock);
    check("to_ts_read_cycles", addr1_cycles - c0, 16);

    // Fifteen stalls is just inside the limit.
    run_txn(0, 15, EXP_ID, EXP_TS, lat);
    check("stall15_latency", lat, 17);
    check("stall15_flags", {timeout, pass}, 2'b01);

    // Timeout on the ID read skips the timestamp read.
    run_txn(16, 0, EXP_ID, EXP_TS, lat);
    check("to_id_latency", lat, 16);
    check("to_id_state", {timeout, id_mismatch, pass, id_value, ts_value}, {3'b100, 64'd0});

    // Extra starts while busy and on the done cycle.
    plan_stall[0] = 3;
    plan_stall[1] = 3;
    plan_data[0]  = EXP_ID;
    plan_data[1]  = EXP_TS;
    repeat (2) @(negedge clock);
    a0 = accepts;
    start = 1'b1;
    @(negedge clock);
    lat = 0;
    while (done !== 1'b1 && lat < 300) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clock);
      lat++;
    end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    check("extra_start_latency", lat, 8);
    check("extra_start_reads", accepts - a0, 2);
    check("extra_start_idle", busy, 0);

    // Randomised transactions.
    for (int i = 0; i < 40; i++) begin
      int sid, sts;
      logic [31:0] did, dts;
      sid = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 6);
      sts = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 6);
      did = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
      dts = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
      run_txn(sid, sts, did, dts, lat);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    // Reset in the middle of a stalled ID read.
    run_txn_start_only(100);
    repeat (3) @(negedge clock);
    check("pre_reset_read", {read, address}, 2'b10);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs",
          {read, busy, done, pass, id_mismatch, ts_mismatch, timeout, id_value, ts_value}, '0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    run_txn(0, 0, EXP_ID, EXP_TS, lat);
    check("post_reset_latency", lat, 2);
    check("post_reset_pass", pass, 1);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  task automatic run_txn_start_only(input int sid);
    plan_stall[0] = sid;
    plan_stall[1] = 0;
    plan_data[0]  = EXP_ID;
    plan_data[1]  = EXP_TS;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

endmodule
